// File: rtl/bram_readout_ctrl.sv
// Streams a burst of words out of a 2-cycle-latency block RAM into a ready/valid port.
// Reads are throttled so the 4-entry output FIFO can never overflow.
module bram_readout_ctrl #(
    parameter int RAM_WIDTH  = 8,
    parameter int RAM_DEPTH  = 16,
    parameter int ADDR_WIDTH = $clog2(RAM_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] address_bus,
    output logic                  enable,
    output logic                  write_enable,
    output logic                  register_enable,
    input  logic [RAM_WIDTH-1:0]  data_output,
    output logic [RAM_WIDTH-1:0]  m_data,
    output logic                  m_valid,
    input  logic                  m_ready
);
    localparam int LW = ADDR_WIDTH + 1;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
    localparam logic [LW-1:0]         DEPTH_LEN = LW'(RAM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

    logic [1:0]            state_reg, state_next;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [LW-1:0]         issue_left_reg;
    logic [LW-1:0]         accept_left_reg;
    logic [LW-1:0]         len_sat;
    logic [1:0]            inflight_reg;
    logic [RAM_WIDTH-1:0]  fifo_mem [4];
    logic [1:0]            wr_ptr_reg, rd_ptr_reg;
    logic [2:0]            count_reg;
    logic [2:0]            outstanding;
    logic                  issue_first, issue_read, issue, push, pop;
    logic [ADDR_WIDTH-1:0] issue_addr, addr_inc;

    assign len_sat     = (length > DEPTH_LEN) ? DEPTH_LEN : length;
    assign outstanding = count_reg + {2'b00, inflight_reg[0]} + {2'b00, inflight_reg[1]};

    // The first read goes out in the start cycle itself so the first word reaches
    // the FIFO output three cycles after start.
    assign issue_first = (state_reg == IDLE) && start && (len_sat != '0);
    assign issue_read  = (state_reg == READ) && (issue_left_reg != '0) && (outstanding < 3'd4);
    assign issue       = issue_first | issue_read;
    assign issue_addr  = issue_first ? start_addr : addr_reg;
    assign addr_inc    = (issue_addr == LAST_ADDR) ? '0 : issue_addr + ADDR_WIDTH'(1);

    assign push = inflight_reg[1];
    assign pop  = m_valid && m_ready;

    assign busy            = (state_reg == READ) || (state_reg == DRAIN);
    assign done            = (state_reg == DONE);
    assign enable          = issue;
    assign address_bus     = issue_addr;
    assign write_enable    = 1'b0;
    assign register_enable = busy;
    assign m_valid         = (count_reg != 3'd0);
    assign m_data          = fifo_mem[rd_ptr_reg];

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:  if (start) state_next = (len_sat == '0) ? DONE : READ;
            READ:  if ((issue_left_reg == '0) || (issue_read && issue_left_reg == LW'(1)))
                       state_next = DRAIN;
            DRAIN: if (pop && accept_left_reg == LW'(1)) state_next = DONE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg       <= IDLE;
            addr_reg        <= '0;
            issue_left_reg  <= '0;
            accept_left_reg <= '0;
            inflight_reg    <= '0;
        end else begin
            state_reg    <= state_next;
            inflight_reg <= {inflight_reg[0], issue};
            if (issue) addr_reg <= addr_inc;
            if (issue_first) begin
                issue_left_reg  <= len_sat - LW'(1);
                accept_left_reg <= len_sat;
            end else begin
                if (issue_read) issue_left_reg  <= issue_left_reg - LW'(1);
                if (pop)        accept_left_reg <= accept_left_reg - LW'(1);
            end
        end
    end

    // Output FIFO: the in-flight tag marks the cycle data_output carries a requested word.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            for (int i = 0; i < 4; i++) fifo_mem[i] <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr_reg] <= data_output;
                wr_ptr_reg           <= wr_ptr_reg + 2'd1;
            end
            if (pop) rd_ptr_reg <= rd_ptr_reg + 2'd1;
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_readout_ctrl.sv
// Bench for bram_readout_ctrl: 2-cycle RAM model, burst-level scoreboard checked every
// cycle, and directed bursts with literal expectations.
module tb_bram_readout_ctrl;
    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset, start, m_ready;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy, done, enable, write_enable, register_enable, m_valid;
    logic [AW-1:0] address_bus;
    logic [W-1:0]  data_output, m_data;

    always #5 clock = ~clock;

    bram_readout_ctrl #(.RAM_WIDTH(W), .RAM_DEPTH(D), .ADDR_WIDTH(AW)) dut (
        .clock(clock), .reset(reset), .start(start), .start_addr(start_addr),
        .length(length), .busy(busy), .done(done), .address_bus(address_bus),
        .enable(enable), .write_enable(write_enable), .register_enable(register_enable),
        .data_output(data_output), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready)
    );

    // RAM: address registered on enable, output register on register_enable.
    logic [W-1:0] mem [D];
    logic [W-1:0] ram_stage;
    initial begin
        ram_stage   = '0;
        data_output = '0;
    end
    always @(posedge clock) begin
        if (enable) ram_stage <= mem[address_bus];
        if (register_enable) data_output <= ram_stage;
    end

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got_v, input logic [31:0] exp_v);
        n_cmp++;
        if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got_v, exp_v, cyc);
        end
    endtask

    // Burst-level model
    logic [W-1:0] exp_q[$];
    logic [W-1:0] got[$];
    bit           busy_exp = 0, done_exp = 0, hold_prev = 0;
    logic [W-1:0] data_prev;
    int issued = 0, popped = 0, burst_len = 0;
    int start_cyc = 0, first_valid_cyc = -1, done_cyc = -1;

    always @(negedge clock) begin
        bit nb, nd;
        int len;
        if (reset) begin
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_enable", enable, 0);
            check("rst_reg_en", register_enable, 0);
            check("rst_m_valid", m_valid, 0);
            check("rst_address", address_bus, 0);
            check("rst_m_data", m_data, 0);
            exp_q.delete();
            busy_exp = 0; done_exp = 0; hold_prev = 0;
            issued = 0; popped = 0; burst_len = 0;
        end else begin
            nb = busy_exp;
            nd = 0;
            check("busy", busy, busy_exp);
            check("done", done, done_exp);
            check("write_enable", write_enable, 0);
            check("register_enable", register_enable, busy_exp);
            if (done) done_cyc = cyc;
            if (hold_prev) begin
                check("hold_valid", m_valid, 1);
                check("hold_data", m_data, data_prev);
            end
            if (start && !busy_exp && !done_exp) begin
                len = (length > D) ? D : int'(length);
                start_cyc = cyc;
                burst_len = len;
                issued = 0;
                popped = 0;
                if (len == 0) begin
                    nd = 1;
                end else begin
                    nb = 1;
                    for (int i = 0; i < len; i++) exp_q.push_back(mem[(int'(start_addr) + i) % D]);
                end
            end
            if (enable) begin
                check("outstanding_lt4", (issued - popped) < 4, 1);
                check("read_within_len", issued < burst_len, 1);
                issued++;
            end
            if (exp_q.size() == 0) check("no_valid_when_idle", m_valid, 0);
            if (m_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (m_valid && m_ready && exp_q.size() != 0) begin
                check("m_data", m_data, exp_q[0]);
                got.push_back(m_data);
                void'(exp_q.pop_front());
                popped++;
                if (exp_q.size() == 0) begin
                    nd = 1;
                    nb = 0;
                    check("reads_issued", issued, popped);
                end
            end
            hold_prev = m_valid && !m_ready;
            data_prev = m_data;
            busy_exp  = nb;
            done_exp  = nd;
        end
    end

    logic pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic launch(input int a, input int l);
        got.delete();
        first_valid_cyc = -1;
        done_cyc = -1;
        start_addr = AW'(a);
        length = (AW+1)'(l);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input bit toggle);
        int k = 0;
        bit seen = 0;
        while (!seen && k < budget) begin
            if (toggle) m_ready = pat[k % 4];
            @(negedge clock);
            if (done) seen = 1;
            tick();
            k++;
        end
        m_ready = 1'b1;
        check("done_within_budget", seen, 1);
    endtask

    task automatic load_mem(input int mult);
        for (int i = 0; i < D; i++) mem[i] = W'(i * mult);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int k;
        reset = 1'b1; start = 1'b0; m_ready = 1'b1; start_addr = '0; length = '0;
        load_mem(1);
        tick(); tick();
        check("reset_m_valid", m_valid, 0);
        check("reset_busy", busy, 0);
        reset = 1'b0;
        tick();

        // Full-depth burst, m_ready high
        launch(0, 16);
        wait_done(60, 0);
        check("b1_count", got.size(), 16);
        for (int i = 0; i < 16; i++) check("b1_word", got[i], i);
        check("b1_first_valid_latency", first_valid_cyc - start_cyc, 3);
        check("b1_done_latency", done_cyc - start_cyc, 19);
        tick();

        // Address wrap
        load_mem(2);
        launch(14, 4);
        wait_done(40, 0);
        check("b2_count", got.size(), 4);
        check("b2_w0", got[0], 28);
        check("b2_w1", got[1], 30);
        check("b2_w2", got[2], 0);
        check("b2_w3", got[3], 2);

        // Backpressure 1,0,0,1
        load_mem(1);
        launch(0, 8);
        wait_done(80, 1);
        check("b3_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("b3_word", got[i], i);

        // Zero length
        launch(0, 0);
        wait_done(10, 0);
        check("b4_done_latency", done_cyc - start_cyc, 1);
        check("b4_count", got.size(), 0);

        // Oversized length saturates
        launch(5, 20);
        wait_done(60, 0);
        check("b5_count", got.size(), 16);
        check("b5_first", got[0], 5);
        check("b5_last", got[15], 4);

        // Start while busy is ignored
        launch(0, 8);
        tick(); tick();
        launch(9, 4);
        wait_done(60, 0);
        check("b6_count", got.size(), 8);
        for (int i = 0; i < 8; i++) check("b6_word", got[i], i);
        tick();

        // Reset mid-burst, then a fresh burst
        launch(0, 16);
        k = 0;
        while (got.size() < 5 && k < 60) begin
            tick();
            k++;
        end
        check("b7_five_words", got.size(), 5);
        reset = 1'b1;
        #1;
        check("b7_abort_m_valid", m_valid, 0);
        check("b7_abort_busy", busy, 0);
        check("b7_abort_address", address_bus, 0);
        tick(); tick();
        reset = 1'b0;
        for (int i = 0; i < 6; i++) tick();
        check("b7_no_more_words", got.size(), 5);
        launch(3, 2);
        wait_done(30, 0);
        check("b8_count", got.size(), 2);
        check("b8_w0", got[0], 3);
        check("b8_w1", got[1], 4);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/bram_readout_ctrl.md
BRAM_READOUT_CTRL -- requirements
Module: bram_readout_ctrl

Interface
REQ-001 Parameter RAM_WIDTH, default 8: data word width in bits.
REQ-002 Parameter RAM_DEPTH, default 16: number of RAM entries.
REQ-003 Parameter ADDR_WIDTH, default clog2(RAM_DEPTH): RAM address width.
REQ-004 Port clock  input  1  single clock; all logic SHALL be rising-edge clocked.
REQ-005 Port reset  input  1  asynchronous, active-high reset.
REQ-006 Port start  input  1  one-cycle pulse that launches a readout burst.
REQ-007 Port start_addr  input  ADDR_WIDTH  first RAM address of the burst.
REQ-008 Port length  input  ADDR_WIDTH+1  number of words to read.
REQ-009 Port busy  output  1  high from the cycle after an accepted start until done.
REQ-010 Port done  output  1  one-cycle pulse when the last word is accepted downstream.
REQ-011 Port address_bus  output  ADDR_WIDTH  RAM address.
REQ-012 Port enable  output  1  RAM enable, high only on read-issue cycles.
REQ-013 Port write_enable  output  1  RAM write enable, tied low.
REQ-014 Port register_enable  output  1  RAM output-register enable, high whenever busy.
REQ-015 Port data_output  input  RAM_WIDTH  RAM read data.
REQ-016 Port m_data  output  RAM_WIDTH  streamed word.
REQ-017 Port m_valid  output  1  m_data is valid.
REQ-018 Port m_ready  input  1  downstream accepts a word when m_valid and m_ready are both high.

Function
REQ-019 The block SHALL assume a fixed RAM read latency of 2 cycles: a word addressed with enable high in cycle N appears on data_output in cycle N+2.
REQ-020 FSM states SHALL be IDLE, READ, DRAIN, DONE; IDLE->READ on start in IDLE with length!=0; READ->DRAIN when the last address is issued; DRAIN->DONE when the last word is accepted; DONE->IDLE after one cycle.
REQ-021 start with length=0 SHALL go IDLE->DONE directly, issue no reads, and pulse done.
REQ-022 length > RAM_DEPTH SHALL saturate to RAM_DEPTH.
REQ-023 start outside IDLE SHALL be ignored.
REQ-024 The address SHALL increment by 1 per issued read and wrap from RAM_DEPTH-1 to 0.
REQ-025 Read data SHALL enter a 4-entry output FIFO tagged by a 2-deep in-flight valid shift register.
REQ-026 A read SHALL issue only when FIFO occupancy plus in-flight count is less than 4, so no word is ever dropped.
REQ-027 m_valid SHALL equal FIFO non-empty; m_data SHALL be the FIFO head; words SHALL be held stable while m_valid is high and m_ready is low.
REQ-028 Simultaneous FIFO push and pop SHALL leave occupancy unchanged.
REQ-029 With m_ready held high, throughput SHALL be 1 word per cycle, and the first m_valid SHALL occur 3 cycles after start.
REQ-030 Words SHALL be emitted in issue order, exactly length words per burst.
REQ-031 done SHALL assert in the cycle after the final handshake; busy SHALL deassert in that same cycle.

Reset
REQ-032 On reset assertion the FSM SHALL enter IDLE; busy, done, enable, register_enable, and m_valid SHALL be 0; address_bus, m_data, and FIFO pointers SHALL be 0; the in-flight register SHALL be cleared.
REQ-033 Reset mid-burst SHALL abort the burst without a done pulse, and no stale word SHALL appear after release.
REQ-034 RAM contents are outside this block and SHALL NOT be affected by its reset.

Verification
REQ-035 RAM preloaded with mem[i]=i; start_addr=0, length=16, m_ready=1 -> m_data = 0..15 on 16 consecutive cycles, then done for 1 cycle.
REQ-036 mem[i]=2*i; start_addr=14, length=4 -> output 28, 30, 0, 2 (address wrap), then done.
REQ-037 start_addr=0, length=8, m_ready toggled 1,0,0,1 repeatedly -> exactly 0..7 emitted, no duplicates or losses, enable never issues with 4 words outstanding.
REQ-038 length=0 -> done pulses 1 cycle after start, enable never high, m_valid never high; length=20 -> exactly 16 words output.
REQ-039 reset asserted after the 5th accepted word of a 16-word burst -> outputs cleared immediately, no done pulse; a new start_addr=3, length=2 burst then outputs 3 and 4 correctly.
REQ-040 start pulsed again while busy -> ignored; the original burst completes unchanged.
